otter_intr_ctrl: RTL
====================

Name: otter_intr_ctrl

Overview:
Multi-source interrupt controller that schedules external interrupt requesters onto the MCU's single interrupt line (the CS_INTR input of the control FSM). It synchronizes and latches requests, then masks them. It arbitrates by fixed priority (lowest index wins) and presents one request at a time. The in-service interrupt is tracked from the FSM's int_taken pulse until mret_exec. Software configures it through a small MMIO register window on the data-memory bus.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32)
SYNC_STAGES, 2, synchronizer flops per IRQ input (>=2)
ID_W, $clog2(NUM_SRC) (min 1), width of source ID

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
IRQ_IN  in  NUM_SRC  asynchronous interrupt request lines
INT_TAKEN  in  1  one-cycle pulse from control FSM: interrupt entered
MRET_EXEC  in  1  one-cycle pulse from control FSM: mret executed
CFG_WE  in  1  MMIO write strobe
CFG_ADDR  in  2  register select: 0 ENABLE, 1 PENDING, 2 ACTIVE_ID, 3 MODE
CFG_WDATA  in  32  MMIO write data
CFG_RDATA  out  32  MMIO read data, combinational from CFG_ADDR
INTR_OUT  out  1  interrupt request to CSR/control FSM
INTR_ID  out  ID_W  ID of requested/in-service source
IN_SERVICE  out  1  high between INT_TAKEN and MRET_EXEC

Behaviour:
- Reset: state IDLE. ENABLE, PENDING, MODE, sync chains, edge history, INTR_ID are 0; INTR_OUT=0; IN_SERVICE=0.
- Per source i: SYNC_STAGES-flop synchronizer, then a previous-value flop.
- MODE[i]=0 (edge): PENDING[i] sets on sync rising edge, held until cleared.
- MODE[i]=1 (level): PENDING[i] follows the synchronized level each cycle; W1C has no effect.
- Latency: IRQ_IN[i] sampled high at edge k -> PENDING[i]=1 after edge k+SYNC_STAGES -> INTR_OUT=1 after edge k+SYNC_STAGES+1.
- Eligible vector = PENDING & ENABLE. Winner = lowest set index.
- State machine, with outputs decoded from state:
  - IDLE: INTR_OUT=0. If any eligible bit: latch winner into INTR_ID and go to REQUEST.
  - REQUEST: INTR_OUT=1. On INT_TAKEN: clear PENDING[INTR_ID] (edge mode) and go to SERVICE. Else if the latched source is no longer eligible (disabled, W1C, or level dropped): go to IDLE (withdraw).
  - SERVICE: INTR_OUT=0, IN_SERVICE=1. No nesting; new requests stay pending. On MRET_EXEC: go to IDLE.
- Arbitration is re-evaluated only in IDLE. A higher-priority arrival during REQUEST does not preempt it.
- Simultaneous edge-set and W1C clear on the same bit in the same cycle: set wins.
- Simultaneous INT_TAKEN and withdraw condition in REQUEST: INT_TAKEN wins.
- MRET_EXEC outside SERVICE and INT_TAKEN outside REQUEST are ignored.
- MMIO writes take effect at the next edge:
  - ENABLE: plain write of the low NUM_SRC bits.
  - PENDING: write-1-to-clear.
  - ACTIVE_ID: read-only.
  - MODE: plain write.
- MMIO reads: unused upper bits read 0. ACTIVE_ID reads {IN_SERVICE at bit 31, INTR_ID zero-extended}.
- Upper bits of CFG_WDATA beyond NUM_SRC are ignored.
- RST during REQUEST or SERVICE: immediate return to IDLE with all registers cleared.

Decomposition:
- Package otter_intr_pkg holds:
  - state enum {IDLE, REQUEST, SERVICE};
  - register offsets REG_ENABLE=0, REG_PENDING=1, REG_ACTIVE_ID=2, REG_MODE=3;
  - bit position ACTIVE_INSVC_BIT=31.
- Sub-module otter_irq_sync: one instance per source. It contains the synchronizer chain plus edge detect and outputs sync_level and rise_pulse.
- The top level holds the registers, priority encoder, FSM and MMIO decode.

Test Plan:
- Reset, ENABLE=0x01, pulse IRQ_IN[0] high for 1 cycle at edge k -> PENDING=0x01 after k+2; INTR_OUT=1, INTR_ID=0 after k+3.
- ENABLE=0xFF, raise IRQ_IN[5] and IRQ_IN[2] together -> INTR_ID=2. INT_TAKEN -> PENDING=0x20, IN_SERVICE=1, INTR_OUT=0. MRET_EXEC -> next request INTR_ID=5.
- In REQUEST for ID 3, write ENABLE=0x00 -> back to IDLE next edge, INTR_OUT=0, PENDING[3] still 1. Re-enable -> INTR_OUT re-asserts with ID 3.
- MODE[1]=1, hold IRQ_IN[1] high, take and mret -> re-request ID 1 immediately. Drop IRQ_IN[1] while in REQUEST -> withdraw to IDLE.
- Same-cycle W1C of PENDING[4] with a new IRQ_IN[4] rising edge reaching the detector -> PENDING[4] remains 1.
- Assert RST while in SERVICE -> next edge: IN_SERVICE=0, INTR_OUT=0, all CFG registers read 0x00000000.

Source files
------------

// File: rtl/otter_intr_pkg.sv
// Shared types and constants for the OTTER interrupt controller.
package otter_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

    localparam logic [1:0] REG_ENABLE    = 2'd0;
    localparam logic [1:0] REG_PENDING   = 2'd1;
    localparam logic [1:0] REG_ACTIVE_ID = 2'd2;
    localparam logic [1:0] REG_MODE      = 2'd3;

    localparam int ACTIVE_INSVC_BIT = 31;

    // Index of the lowest set bit; scanning downward lets the lowest index overwrite.
    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/otter_irq_sync.sv
// Per-source synchronizer chain with a trailing history flop for rising-edge detect.
module otter_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    output logic sync_level_o,
    output logic rise_pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer shift chain and previous-value flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_level_o = sync_q[SYNC_STAGES-1];
    assign rise_pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Fixed-priority interrupt controller feeding the single CS_INTR line of the control FSM,
// with an MMIO window for enable, pending (W1C), active ID and edge/level mode.
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               INT_TAKEN,
    input  logic               MRET_EXEC,
    input  logic               CFG_WE,
    input  logic [1:0]         CFG_ADDR,
    input  logic [31:0]        CFG_WDATA,
    output logic [31:0]        CFG_RDATA,
    output logic               INTR_OUT,
    output logic [ID_W-1:0]    INTR_ID,
    output logic               IN_SERVICE
);

    logic [NUM_SRC-1:0] sync_level_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [NUM_SRC-1:0] take_clr_s;
    logic [NUM_SRC-1:0] wdata_src_s;
    logic [ID_W-1:0]    intr_id_q, intr_id_d;
    logic [ID_W-1:0]    winner_s;
    logic               take_s;
    intr_state_e        state_q, state_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        otter_irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i        (CLK),
            .rst_i        (RST),
            .irq_i        (IRQ_IN[g]),
            .sync_level_o (sync_level_s[g]),
            .rise_pulse_o (rise_s[g])
        );
    end

    assign wdata_src_s = CFG_WDATA[NUM_SRC-1:0];
    assign eligible_s  = pending_q & enable_q;
    assign winner_s    = ID_W'(lowest_set(32'(eligible_s)));

    // Arbitration and service-tracking state machine.
    always_comb begin
        state_d   = state_q;
        intr_id_d = intr_id_q;
        take_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible_s) begin
                    intr_id_d = winner_s;
                    state_d   = REQUEST;
                end else begin
                    state_d = IDLE;
                end
            end
            REQUEST: begin
                // Taking the interrupt beats a same-cycle withdraw.
                if (INT_TAKEN) begin
                    take_s  = 1'b1;
                    state_d = SERVICE;
                end else if (!eligible_s[intr_id_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQUEST;
                end
            end
            SERVICE: begin
                if (MRET_EXEC) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration register next-state and pending set/clear logic.
    always_comb begin
        enable_d   = enable_q;
        mode_d     = mode_q;
        w1c_s      = {NUM_SRC{1'b0}};
        take_clr_s = {NUM_SRC{1'b0}};
        if (CFG_WE) begin
            case (CFG_ADDR)
                REG_ENABLE:  enable_d = wdata_src_s;
                REG_PENDING: w1c_s    = wdata_src_s;
                REG_MODE:    mode_d   = wdata_src_s;
                default:     enable_d = enable_q;
            endcase
        end else begin
            enable_d = enable_q;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            take_clr_s[i] = take_s && (intr_id_q == ID_W'(i));
        end
        // Level sources mirror the synchronized line; edge sources latch with set over clear.
        pending_d = (mode_q & sync_level_s)
                  | (~mode_q & ((pending_q & ~(w1c_s | take_clr_s)) | rise_s));
    end

    // State and configuration registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            intr_id_q <= {ID_W{1'b0}};
            enable_q  <= {NUM_SRC{1'b0}};
            pending_q <= {NUM_SRC{1'b0}};
            mode_q    <= {NUM_SRC{1'b0}};
        end else begin
            state_q   <= state_d;
            intr_id_q <= intr_id_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
        end
    end

    // MMIO read mux.
    always_comb begin
        CFG_RDATA = 32'h0000_0000;
        case (CFG_ADDR)
            REG_ENABLE:  CFG_RDATA = 32'(enable_q);
            REG_PENDING: CFG_RDATA = 32'(pending_q);
            REG_ACTIVE_ID: begin
                CFG_RDATA                   = 32'(intr_id_q);
                CFG_RDATA[ACTIVE_INSVC_BIT] = (state_q == SERVICE);
            end
            REG_MODE:    CFG_RDATA = 32'(mode_q);
            default:     CFG_RDATA = 32'h0000_0000;
        endcase
    end

    assign INTR_OUT   = (state_q == REQUEST);
    assign IN_SERVICE = (state_q == SERVICE);
    assign INTR_ID    = intr_id_q;

endmodule
